kogge_stone_adder: RTL and testbench

- Parameterised Kogge-Stone parallel-prefix adder computing a + b + cin with full carry-out, result registered on the single clock.
- Default configuration is 4-bit operands with a 5-bit sum.
- Generic arithmetic leaf block, used wherever a low-depth adder with a registered result is needed.

---
 rtl/ksa_pkg.sv | 24 ++
 rtl/kogge_stone_adder_if.sv | 24 ++
 rtl/ksa_prefix_cell.sv | 11 +
 rtl/kogge_stone_adder.sv | 115 +++++++++++
 tb/tb_kogge_stone_adder.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/ksa_pkg.sv
// Shared types and helpers for the Kogge-Stone adder: default width,
// prefix-tree depth calculation and the generate/propagate pair type.
package ksa_pkg;

   localparam int KSA_WIDTH_DEF = 4;

   typedef struct packed {
      logic g;
      logic p;
   } gp_t;

   // Number of prefix levels needed to span WIDTH bits plus the carry-in node.
   function automatic int ksa_levels(input int width);
      int n;
      n = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < width + 1) begin
            n = i + 1;
         end
      end
      return n;
   endfunction

endpackage

// File: rtl/kogge_stone_adder_if.sv
// Operand/result bus of the Kogge-Stone adder; master drives operands,
// slave (the adder) returns the registered sum.
interface kogge_stone_adder_if
   import ksa_pkg::*;
#(
   parameter int WIDTH = KSA_WIDTH_DEF
);
   logic             in_valid;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic [WIDTH:0]   s;

   modport master (
      output in_valid, a, b, cin,
      input  out_valid, s
   );

   modport slave (
      input  in_valid, a, b, cin,
      output out_valid, s
   );
endinterface

// File: rtl/ksa_prefix_cell.sv
// Kogge-Stone black cell: merges a higher and a lower generate/propagate
// span into one covering both.
module ksa_prefix_cell
   import ksa_pkg::*;
(
   input  gp_t hi,
   input  gp_t lo,
   output gp_t out
);
   assign out = gp_t'{g: hi.g | (hi.p & lo.g), p: hi.p & lo.p};
endmodule

// File: rtl/kogge_stone_adder.sv
// Registered Kogge-Stone adder computing a + b + cin with carry-out.
// Define KSA_PIPE_EN to register the prefix-tree result (latency 2).
module kogge_stone_adder
   import ksa_pkg::*;
#(
   parameter int WIDTH = KSA_WIDTH_DEF
)(
   input logic                 clk,
   input logic                 rst,
   kogge_stone_adder_if.slave  bus
);
   localparam int LEVELS = ksa_levels(WIDTH);
   localparam int NODES  = WIDTH + 1;

   // Node 0 is the carry-in (bit -1); node i+1 is operand bit i.
   gp_t              tree [LEVELS+1][NODES];
   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] prop;

   assign tree[0][0] = gp_t'{g: bus.cin, p: 1'b0};

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pre
      assign tree[0][gi+1] = gp_t'{g: bus.a[gi] & bus.b[gi], p: bus.a[gi] ^ bus.b[gi]};
   end

   for (genvar gk = 0; gk < LEVELS; gk++) begin : g_level
      for (genvar gi = 0; gi < NODES; gi++) begin : g_node
         if (gi >= (1 << gk)) begin : g_cell
            ksa_prefix_cell u_cell (
               .hi  (tree[gk][gi]),
               .lo  (tree[gk][gi - (1 << gk)]),
               .out (tree[gk+1][gi])
            );
         end else begin : g_pass
            assign tree[gk+1][gi] = tree[gk][gi];
         end
      end
   end

   // After the last level node i holds G[i-1:-1], the carry into bit i.
   for (genvar gi = 0; gi < NODES; gi++) begin : g_carry
      assign carry[gi] = tree[LEVELS][gi].g;
   end

   assign prop = bus.a ^ bus.b;

   logic [WIDTH:0]   post_carry;
   logic [WIDTH-1:0] post_prop;
   logic             post_valid;

`ifdef KSA_PIPE_EN
   logic [WIDTH:0]   carry_q, carry_d;
   logic [WIDTH-1:0] prop_q, prop_d;
   logic             mid_valid_q, mid_valid_d;

   always_comb begin
      carry_d     = carry_q;
      prop_d      = prop_q;
      mid_valid_d = bus.in_valid;
      if (bus.in_valid) begin
         carry_d = carry;
         prop_d  = prop;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         carry_q     <= '0;
         prop_q      <= '0;
         mid_valid_q <= 1'b0;
      end else begin
         carry_q     <= carry_d;
         prop_q      <= prop_d;
         mid_valid_q <= mid_valid_d;
      end
   end

   assign post_carry = carry_q;
   assign post_prop  = prop_q;
   assign post_valid = mid_valid_q;
`else
   assign post_carry = carry;
   assign post_prop  = prop;
   assign post_valid = bus.in_valid;
`endif

   logic [WIDTH:0] sum;
   logic [WIDTH:0] s_q, s_d;
   logic           out_valid_q, out_valid_d;

   assign sum = {post_carry[WIDTH], post_prop ^ post_carry[WIDTH-1:0]};

   // The sum register holds its last result across idle cycles.
   always_comb begin
      s_d         = s_q;
      out_valid_d = post_valid;
      if (post_valid) begin
         s_d = sum;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s_q         <= '0;
         out_valid_q <= 1'b0;
      end else begin
         s_q         <= s_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.s         = s_q;
   assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_kogge_stone_adder.sv
// Self-checking bench for kogge_stone_adder at WIDTH 4, 5 and 8; results are
// scored against queues of expected sums filled as operands are driven.
module tb_kogge_stone_adder;
   import ksa_pkg::*;

`ifdef KSA_PIPE_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   typedef struct {
      int a;
      int b;
      int cin;
      int exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;
   int   q4[$];
   int   q5[$];
   int   q8[$];

   kogge_stone_adder_if #(.WIDTH(4)) if4 ();
   kogge_stone_adder_if #(.WIDTH(5)) if5 ();
   kogge_stone_adder_if #(.WIDTH(8)) if8 ();

   kogge_stone_adder #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
   kogge_stone_adder #(.WIDTH(5)) dut5 (.clk(clk), .rst(rst), .bus(if5.slave));
   kogge_stone_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8.slave));

   always #5 clk = ~clk;

   task automatic check(input string name, input logic ok, input int act, input int exp);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic drive4(input logic v, input int a, input int b, input int c, input int exp);
      @(negedge clk);
      if4.in_valid = v;
      if4.a        = 4'(a);
      if4.b        = 4'(b);
      if4.cin      = 1'(c);
      if (v) q4.push_back(exp);
   endtask

   task automatic drive58(input logic v, input int a5, input int b5, input int c5,
                          input int a8, input int b8, input int c8);
      @(negedge clk);
      if5.in_valid = v;
      if5.a        = 5'(a5);
      if5.b        = 5'(b5);
      if5.cin      = 1'(c5);
      if8.in_valid = v;
      if8.a        = 8'(a8);
      if8.b        = 8'(b8);
      if8.cin      = 1'(c8);
      if (v) begin
         q5.push_back(a5 + b5 + c5);
         q8.push_back(a8 + b8 + c8);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (if4.out_valid === 1'b1) begin
         if (q4.size() == 0) begin
            check("w4_unexpected_valid", 1'b0, int'(if4.s), -1);
         end else begin
            int e4;
            e4 = q4.pop_front();
            $display("w4 result s=%0d expected=%0d", int'(if4.s), e4);
            check("w4_sum", !$isunknown(if4.s) && (int'(if4.s) == e4), int'(if4.s), e4);
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (if5.out_valid === 1'b1) begin
         if (q5.size() == 0) begin
            check("w5_unexpected_valid", 1'b0, int'(if5.s), -1);
         end else begin
            int e5;
            e5 = q5.pop_front();
            check("w5_sum", !$isunknown(if5.s) && (int'(if5.s) == e5), int'(if5.s), e5);
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (if8.out_valid === 1'b1) begin
         if (q8.size() == 0) begin
            check("w8_unexpected_valid", 1'b0, int'(if8.s), -1);
         end else begin
            int e8;
            e8 = q8.pop_front();
            check("w8_sum", !$isunknown(if8.s) && (int'(if8.s) == e8), int'(if8.s), e8);
         end
      end
   end

   initial begin
      vec_t corners[8];
      corners[0] = '{a: 15, b: 15, cin: 1, exp: 31};
      corners[1] = '{a: 0,  b: 0,  cin: 0, exp: 0};
      corners[2] = '{a: 8,  b: 8,  cin: 0, exp: 16};
      corners[3] = '{a: 15, b: 0,  cin: 1, exp: 16};
      corners[4] = '{a: 1,  b: 1,  cin: 0, exp: 2};
      corners[5] = '{a: 2,  b: 2,  cin: 1, exp: 5};
      corners[6] = '{a: 15, b: 1,  cin: 0, exp: 16};
      corners[7] = '{a: 7,  b: 9,  cin: 1, exp: 17};

      if4.in_valid = 1'b0; if4.a = '0; if4.b = '0; if4.cin = 1'b0;
      if5.in_valid = 1'b0; if5.a = '0; if5.b = '0; if5.cin = 1'b0;
      if8.in_valid = 1'b0; if8.a = '0; if8.b = '0; if8.cin = 1'b0;

      // Reset state
      rst = 1'b1;
      repeat (2) @(negedge clk);
      @(posedge clk);
      #2;
      check("reset_s4", if4.s === 5'd0, int'(if4.s), 0);
      check("reset_ov4", if4.out_valid === 1'b0, int'(if4.out_valid), 0);
      check("reset_s8", if8.s === 9'd0, int'(if8.s), 0);
      check("reset_ov8", if8.out_valid === 1'b0, int'(if8.out_valid), 0);
      @(negedge clk);
      rst = 1'b0;

      // Corner table, rows driven back to back
      for (int i = 0; i < 8; i++) begin
         drive4(1'b1, corners[i].a, corners[i].b, corners[i].cin, corners[i].exp);
      end

      // Exhaustive WIDTH=4
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            for (int c = 0; c < 2; c++) begin
               drive4(1'b1, a, b, c, a + b + c);
            end
         end
      end

      // Reset in the same cycle as a valid operand; in-flight results dropped
      @(negedge clk);
      if4.in_valid = 1'b1; if4.a = 4'd7; if4.b = 4'd9; if4.cin = 1'b1;
      rst = 1'b1;
      q4.delete(); q5.delete(); q8.delete();
      @(posedge clk);
      #2;
      check("rst_mid_s", if4.s === 5'd0, int'(if4.s), 0);
      check("rst_mid_ov", if4.out_valid === 1'b0, int'(if4.out_valid), 0);
      @(negedge clk);
      rst = 1'b0;
      if4.in_valid = 1'b0;
      drive4(1'b0, 0, 0, 0, 0);
      drive4(1'b1, 7, 9, 1, 17);

      // Valid gap: result holds while out_valid drops
      drive4(1'b1, 3, 4, 0, 7);
      for (int k = 1; k <= LAT + 2; k++) begin
         @(posedge clk);
         #2;
         if (k >= LAT) begin
            check("gap_hold_s", if4.s === 5'd7, int'(if4.s), 7);
            check("gap_ov", if4.out_valid === ((k == LAT) ? 1'b1 : 1'b0),
                  int'(if4.out_valid), (k == LAT) ? 1 : 0);
         end
         @(negedge clk);
         if4.in_valid = 1'b0; if4.a = 4'd9; if4.b = 4'd9; if4.cin = 1'b1;
      end

      // Parameter sweep at WIDTH=5 and WIDTH=8
      for (int n = 0; n < 10000; n++) begin
         drive58(($urandom_range(0, 7) != 0) ? 1'b1 : 1'b0,
                 int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 1)),
                 int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 1)));
      end
      drive58(1'b1, 31, 31, 1, 255, 255, 1);
      drive58(1'b1, 31, 31, 0, 255, 255, 0);

      // Drain and confirm every expected result arrived
      @(negedge clk);
      if4.in_valid = 1'b0;
      if5.in_valid = 1'b0;
      if8.in_valid = 1'b0;
      repeat (LAT + 3) @(posedge clk);
      #2;
      check("drain_q4", q4.size() == 0, q4.size(), 0);
      check("drain_q5", q5.size() == 0, q5.size(), 0);
      check("drain_q8", q8.size() == 0, q8.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
